// File: rtl/puf_eval_ctrl.sv
// Sequences REPEAT launch/settle/sample/clear races of an arbiter-PUF chain and majority-votes the samples.
// Latency: accept at edge k -> resp_valid rises at edge k + REPEAT*(SETTLE+3); each evaluation is SETTLE+3 cycles.
// Backpressure: ch_ready only in IDLE; resp_valid and the response fields hold until resp_ready is seen.
module puf_eval_ctrl #(
  parameter int STAGES = 64,
  parameter int REPEAT = 5,
  parameter int SETTLE = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ch_valid,
  input  logic [STAGES-1:0]            ch_data,
  output logic                         ch_ready,
  output logic [STAGES-1:0]            chal,
  output logic                         launch,
  output logic                         arb_clr,
  input  logic                         arb_in,
  output logic                         resp_valid,
  output logic                         resp,
  output logic [$clog2(REPEAT+1)-1:0]  resp_ones,
  output logic                         resp_stable,
  input  logic                         resp_ready
);

  localparam int OW = $clog2(REPEAT + 1);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [OW-1:0] REP_W     = OW'(REPEAT);
  localparam logic [OW:0]   REP_X     = (OW + 1)'(REPEAT);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_SAMPLE,
    ST_CLEAR,
    ST_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [OW-1:0]   ones, ones_nxt;
  logic [OW-1:0]   eval_cnt, eval_nxt;
  logic [STAGES-1:0] chal_nxt;
  logic            launch_nxt, arb_clr_nxt, ch_ready_nxt, resp_valid_nxt;
  logic            resp_load, resp_nxt, stable_nxt;

  // Next-state, datapath updates and the next value of every registered control output
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ones_nxt  = ones;
    eval_nxt  = eval_cnt;
    chal_nxt  = chal;
    case (state)
      ST_IDLE: begin
        if (ch_valid && ch_ready) begin
          chal_nxt  = ch_data;
          ones_nxt  = '0;
          eval_nxt  = '0;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_nxt   = SETTLE_LD;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_SAMPLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_SAMPLE: begin
        ones_nxt  = ones + OW'(arb_in);
        eval_nxt  = eval_cnt + 1'b1;
        state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_nxt = (eval_cnt == REP_W) ? ST_DONE : ST_LAUNCH;
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they change on the same edge as the state
    launch_nxt     = (state_nxt == ST_LAUNCH) || (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
    arb_clr_nxt    = (state_nxt == ST_CLEAR);
    ch_ready_nxt   = (state_nxt == ST_IDLE);
    resp_valid_nxt = (state_nxt == ST_DONE);

    // The vote is captured only when the last evaluation finishes, so it is frozen throughout DONE
    resp_load  = (state == ST_CLEAR) && (state_nxt == ST_DONE);
    resp_nxt   = ({ones, 1'b0} > REP_X);
    stable_nxt = (ones == '0) || (ones == REP_W);
  end

  // State, counters and registered outputs; reset abandons any run in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ones        <= '0;
      eval_cnt    <= '0;
      chal        <= '0;
      launch      <= 1'b0;
      arb_clr     <= 1'b1;
      ch_ready    <= 1'b0;
      resp_valid  <= 1'b0;
      resp        <= 1'b0;
      resp_ones   <= '0;
      resp_stable <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ones       <= ones_nxt;
      eval_cnt   <= eval_nxt;
      chal       <= chal_nxt;
      launch     <= launch_nxt;
      arb_clr    <= arb_clr_nxt;
      ch_ready   <= ch_ready_nxt;
      resp_valid <= resp_valid_nxt;
      if (resp_load) begin
        resp        <= resp_nxt;
        resp_ones   <= ones;
        resp_stable <= stable_nxt;
      end
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Bench for puf_eval_ctrl: table vectors, hand-written corner sequences and randomized runs.
// Latency: checks resp_valid at exactly REPEAT*(SETTLE+3) edges after accept.
// Backpressure: holds resp_ready low and offers a second challenge while a response is pending.
module tb_puf_eval_ctrl;

  localparam int STAGES = 8;
  localparam int REPEAT = 5;
  localparam int SETTLE = 4;
  localparam int EVLEN  = SETTLE + 3;
  localparam int NCYC   = REPEAT * EVLEN;

  logic              clk;
  logic              rst_n;
  logic              ch_valid;
  logic [STAGES-1:0] ch_data;
  logic              ch_ready;
  logic [STAGES-1:0] chal;
  logic              launch;
  logic              arb_clr;
  logic              arb_in;
  logic              resp_valid;
  logic              resp;
  logic [2:0]        resp_ones;
  logic              resp_stable;
  logic              resp_ready;

  int n_cmp = 0;
  int n_err = 0;

  // arb_in value to drive in each cycle of one full run, cycle 0 being the cycle after the accept edge
  logic arb_seq [NCYC];

  typedef struct {
    logic [7:0] ch;
    logic [4:0] samp;   // bit e = arbiter value at the sample point of evaluation e
    logic       exp_resp;
    logic [2:0] exp_ones;
    logic       exp_stable;
  } vec_t;

  vec_t vecs [6];

  puf_eval_ctrl #(.STAGES(STAGES), .REPEAT(REPEAT), .SETTLE(SETTLE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch_valid(ch_valid),
    .ch_data(ch_data),
    .ch_ready(ch_ready),
    .chal(chal),
    .launch(launch),
    .arb_clr(arb_clr),
    .arb_in(arb_in),
    .resp_valid(resp_valid),
    .resp(resp),
    .resp_ones(resp_ones),
    .resp_stable(resp_stable),
    .resp_ready(resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the arbiter is sampled in the cycle SETTLE+1 after each launch rise
  function automatic int model_ones();
    int s = 0;
    for (int e = 0; e < REPEAT; e++) s += int'(arb_seq[e * EVLEN + SETTLE + 1]);
    return s;
  endfunction

  // Put the wanted sample on the sample cycle and its complement everywhere else
  task automatic fill_votes(input logic [4:0] samp);
    for (int c = 0; c < NCYC; c++) begin
      int e = c / EVLEN;
      int p = c % EVLEN;
      arb_seq[c] = (p == SETTLE + 1) ? samp[e] : ~samp[e];
    end
  endtask

  task automatic accept(input logic [7:0] ch, output int waited);
    waited   = 0;
    ch_valid = 1'b1;
    ch_data  = ch;
    while (ch_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    check("accept_ready", 32'(ch_ready), 32'd1);
    tick();
    ch_valid = 1'b0;
    ch_data  = 8'($urandom);
    check("accept_chal", 32'(chal), 32'(ch));
  endtask

  task automatic run_body(input logic [7:0] ch, input logic er, input logic [2:0] eo,
                          input logic es, input bit noise);
    int bad_launch = 0;
    int bad_clr    = 0;
    int bad_busy   = 0;
    for (int c = 0; c < NCYC; c++) begin
      int p = c % EVLEN;
      if (launch !== (p <= SETTLE + 1)) bad_launch++;
      if (arb_clr !== (p == SETTLE + 2)) bad_clr++;
      if (resp_valid !== 1'b0 || ch_ready !== 1'b0 || chal !== ch) bad_busy++;
      arb_in = arb_seq[c];
      if (noise) begin
        resp_ready = 1'($urandom_range(0, 1));
        ch_valid   = 1'($urandom_range(0, 1));
        ch_data    = 8'($urandom);
      end
      tick();
    end
    resp_ready = 1'b0;
    ch_valid   = 1'b0;
    check("launch_shape", 32'(bad_launch), 32'd0);
    check("arb_clr_shape", 32'(bad_clr), 32'd0);
    check("busy_outputs", 32'(bad_busy), 32'd0);
    check("resp_latency", 32'(resp_valid), 32'd1);
    check("resp", 32'(resp), 32'(er));
    check("resp_ones", 32'(resp_ones), 32'(eo));
    check("resp_stable", 32'(resp_stable), 32'(es));
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    tick();
    check("release_ch_ready", 32'(ch_ready), 32'd1);
    check("release_resp_valid", 32'(resp_valid), 32'd0);
    resp_ready = 1'b0;
  endtask

  initial begin
    int w;
    int mo;
    int bad;
    logic [7:0] rch;

    vecs[0] = '{8'hA5, 5'b11111, 1'b1, 3'd5, 1'b1};
    vecs[1] = '{8'h5A, 5'b00101, 1'b0, 3'd2, 1'b0};
    vecs[2] = '{8'hF0, 5'b01011, 1'b1, 3'd3, 1'b0};
    vecs[3] = '{8'h0F, 5'b00000, 1'b0, 3'd0, 1'b1};
    vecs[4] = '{8'h81, 5'b11110, 1'b1, 3'd4, 1'b0};
    vecs[5] = '{8'h7E, 5'b00001, 1'b0, 3'd1, 1'b0};

    rst_n      = 1'b0;
    ch_valid   = 1'b1;
    ch_data    = 8'h55;
    arb_in     = 1'b0;
    resp_ready = 1'b0;

    // Reset with a challenge offered: nothing accepted, clear asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_arb_clr", 32'(arb_clr), 32'd1);
      check("rst_ch_ready", 32'(ch_ready), 32'd0);
      check("rst_launch", 32'(launch), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
    end
    check("rst_chal", 32'(chal), 32'd0);
    check("rst_resp_ones", 32'(resp_ones), 32'd0);
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_resp_stable", 32'(resp_stable), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ch_ready", 32'(ch_ready), 32'd1);
    check("post_rst_arb_clr", 32'(arb_clr), 32'd0);
    check("post_rst_chal", 32'(chal), 32'd0);
    ch_valid = 1'b0;

    // Table-driven vote patterns
    for (int v = 0; v < 6; v++) begin
      fill_votes(vecs[v].samp);
      accept(vecs[v].ch, w);
      run_body(vecs[v].ch, vecs[v].exp_resp, vecs[v].exp_ones, vecs[v].exp_stable, 1'b0);
      release_resp();
    end

    // Back-pressure: response frozen, second challenge held off, then taken in the first IDLE cycle
    fill_votes(5'b01011);
    accept(8'h96, w);
    run_body(8'h96, 1'b1, 3'd3, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      ch_valid = 1'b1;
      ch_data  = 8'hC3;
      arb_in   = 1'($urandom_range(0, 1));
      tick();
      if (resp_valid !== 1'b1 || resp !== 1'b1 || resp_ones !== 3'd3 || resp_stable !== 1'b0 ||
          ch_ready !== 1'b0 || chal !== 8'h96 || launch !== 1'b0)
        bad++;
    end
    check("bp_frozen", 32'(bad), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_release_ready", 32'(ch_ready), 32'd1);
    check("bp_no_early_accept", 32'(chal), 32'h96);
    fill_votes(5'b11111);
    accept(8'hC3, w);
    check("bp_pending_wait", 32'(w), 32'd0);
    run_body(8'hC3, 1'b1, 3'd5, 1'b1, 1'b0);
    release_resp();

    // Reset during the third SETTLE abandons the run
    fill_votes(5'b11111);
    accept(8'h77, w);
    for (int c = 0; c < 2 * EVLEN + 2; c++) begin
      arb_in = 1'b1;
      tick();
    end
    check("midrst_pre_launch", 32'(launch), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_launch", 32'(launch), 32'd0);
    check("midrst_arb_clr", 32'(arb_clr), 32'd1);
    check("midrst_ch_ready", 32'(ch_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_post_ready", 32'(ch_ready), 32'd1);
    check("midrst_post_clr", 32'(arb_clr), 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_valid !== 1'b0 || launch !== 1'b0) bad++;
    end
    check("midrst_no_resp", 32'(bad), 32'd0);
    fill_votes(5'b11111);
    accept(8'h3C, w);
    run_body(8'h3C, 1'b1, 3'd5, 1'b1, 1'b0);
    release_resp();

    // Toggling arbiter: only the value on the sample cycle may count
    for (int c = 0; c < NCYC; c++) arb_seq[c] = 1'(c & 1);
    mo = model_ones();
    accept(8'hE7, w);
    run_body(8'hE7, (2 * mo > REPEAT), 3'(mo), (mo == 0 || mo == REPEAT), 1'b0);
    release_resp();

    // Randomized runs against the reference vote
    for (int r = 0; r < 20; r++) begin
      rch = 8'($urandom);
      for (int c = 0; c < NCYC; c++) arb_seq[c] = 1'($urandom_range(0, 1));
      mo = model_ones();
      accept(rch, w);
      run_body(rch, (2 * mo > REPEAT), 3'(mo), (mo == 0 || mo == REPEAT), 1'b1);
      release_resp();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Sequencer that drives one evaluation of an external arbiter-PUF mux chain. It accepts a challenge over a valid/ready handshake and holds it on the chain's switch-stage select lines. It launches the race REPEAT times, sampling the arbiter after a fixed settle interval each time, and returns a majority-voted response bit with a stability flag. It sits between the challenge source (host/UART bridge) and the switch-box delay chain plus arbiter latch.

## Interface
- STAGES, 64, number of switch stages; challenge width in bits.
- REPEAT, 5, evaluations per challenge; must be odd and ≥1.
- SETTLE, 8, cycles between launch rise and arbiter sample; must be ≥1.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ch_valid  in  1  challenge offered.
- ch_data  in  STAGES  challenge bits.
- ch_ready  out  1  block can accept a challenge.
- chal  out  STAGES  registered select lines to switch stages; bit i drives stage i.
- launch  out  1  race start edge into both chain inputs.
- arb_clr  out  1  clears the external arbiter latch.
- arb_in  in  1  arbiter latch output; already synchronised externally.
- resp_valid  out  1  response available.
- resp  out  1  majority vote of REPEAT samples.
- resp_ones  out  $clog2(REPEAT+1)  count of samples equal to 1.
- resp_stable  out  1  all REPEAT samples identical.
- resp_ready  in  1  consumer accepts response.

## Operation
- FSM states: IDLE, LAUNCH, SETTLE, SAMPLE, CLEAR, DONE.
- IDLE:
  - ch_ready=1.
  - On ch_valid & ch_ready: chal<=ch_data, ones<=0, eval<=0, go to LAUNCH.
- LAUNCH: launch=1 for 1 cycle, then go to SETTLE with settle counter loaded to SETTLE-1.
- SETTLE:
  - launch stays 1; counter decrements.
  - At 0, go to SAMPLE.
- SAMPLE:
  - launch=1.
  - ones<=ones+arb_in; eval<=eval+1; go to CLEAR.
- CLEAR:
  - launch=0, arb_clr=1 for 1 cycle.
  - If eval==REPEAT, go to DONE; else go to LAUNCH.
- DONE:
  - resp_valid=1.
  - resp = (2*ones > REPEAT).
  - resp_ones = ones.
  - resp_stable = (ones==0) | (ones==REPEAT).
  - On resp_ready, go to IDLE.
- chal is held constant from accept until the next accept; it is never altered mid-evaluation.
- ch_ready=0 in every state except IDLE. A ch_valid offered outside IDLE is not consumed.
- The ones counter saturates by construction: at most REPEAT increments.
- resp, resp_ones and resp_stable are registered and stable for the whole time resp_valid is high.

## Timing
- Reset values (rst_n low at a clock edge):
  - state=IDLE, chal=0, launch=0, arb_clr=1, ch_ready=0 during reset.
  - resp_valid=0, resp=0, resp_ones=0, resp_stable=0.
- First cycle after rst_n high: arb_clr=0, ch_ready=1.
- Reset mid-evaluation: abandons the run immediately. launch drops at the next edge, no response is produced, and the challenge is lost.
- Per-evaluation length: SETTLE+3 cycles (LAUNCH 1, SETTLE SETTLE, SAMPLE 1, CLEAR 1).
- Sampling point: arb_in is sampled at the edge ending SAMPLE, i.e. SETTLE+1 cycles after launch rises.
- Latency: if the accept occurs at edge k, resp_valid rises at edge k+REPEAT*(SETTLE+3).
- launch is low for exactly 1 cycle between evaluations.
- Back-pressure: resp_valid holds indefinitely while resp_ready=0.
- Handshakes:
  - resp_ready with resp_valid: the response is consumed and ch_ready=1 in the next cycle.
  - Minimum gap between accepts: REPEAT*(SETTLE+3)+2 cycles.
  - resp_ready while not resp_valid is ignored.
  - ch_valid held high during DONE is accepted in the first IDLE cycle.

## Test plan
- Reset: drive rst_n=0 for 3 cycles with ch_valid=1 -> arb_clr=1, ch_ready=0, launch=0, resp_valid=0; the first cycle after release shows ch_ready=1.
- Basic vote, STAGES=8, REPEAT=5, SETTLE=4: accept 8'hA5 with arb_in=1 constant -> chal=8'hA5, 5 launch pulses each 6 cycles high, resp_valid 35 cycles after accept, resp=1, resp_ones=5, resp_stable=1.
- Noisy majority: arb_in at the 5 samples = 1,0,1,0,0 -> resp=0, resp_ones=2, resp_stable=0; samples 1,1,0,1,0 -> resp=1, resp_ones=3.
- Back-pressure: hold resp_ready=0 for 20 cycles after resp_valid -> outputs frozen, ch_ready=0, a second ch_valid is not accepted; raise resp_ready -> ch_ready=1 the next cycle and the pending challenge is accepted.
- Reset mid-run: assert rst_n=0 during the third SETTLE -> launch=0 and arb_clr=1 the next cycle, no resp_valid ever; after release, a new challenge 8'h3C completes normally.
- Timing of samples: arb_in toggles each cycle -> the sampled value equals arb_in at exactly SETTLE+1 cycles after each launch rise; the bench checks resp_ones against its model.
